// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states, default latencies.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MADD  = 3'd6,
    MDU_MADDU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with fixed-latency busy window.
// Optional accumulate ops (MADD/MADDU) are enabled by defining MUL_DIV_UNIT_MADD_EN.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state, next_state;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic             load, commit, mt_hi, mt_lo;
  logic [31:0]      hi_nxt, lo_nxt, res_hi, res_lo;
  logic             wr_q, wr_c;

  // Divide is done at 33 bits so 0x80000000 / -1 yields 0x80000000 without overflow.
  logic signed [32:0] sa33, sb33;
  logic        [31:0] ub;

  always_comb begin
    sa33   = $signed({A[31], A});
    sb33   = (B == 32'd0) ? 33'sd1 : $signed({B[31], B});
    ub     = (B == 32'd0) ? 32'd1 : B;
    res_hi = '0;
    res_lo = '0;
    wr_c   = 1'b1;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
      MDU_MULTU: {res_hi, res_lo} = 64'({32'd0, A} * {32'd0, B});
      MDU_DIV: begin
        res_lo = 32'(sa33 / sb33);
        res_hi = 32'(sa33 % sb33);
        wr_c   = (B != 32'd0);
      end
      MDU_DIVU: begin
        res_lo = A / ub;
        res_hi = A % ub;
        wr_c   = (B != 32'd0);
      end
`ifdef MUL_DIV_UNIT_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = {HI, LO} + 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
      MDU_MADDU: {res_hi, res_lo} = {HI, LO} + 64'({32'd0, A} * {32'd0, B});
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    commit     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    cnt_load   = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin load = 1'b1; cnt_load = CNT_W'(MULT_CYCLES); end
            MDU_DIV, MDU_DIVU:   begin load = 1'b1; cnt_load = CNT_W'(DIV_CYCLES);  end
            MDU_MTHI:            mt_hi = 1'b1;
            MDU_MTLO:            mt_lo = 1'b1;
`ifdef MUL_DIV_UNIT_MADD_EN
            MDU_MADD, MDU_MADDU: begin load = 1'b1; cnt_load = CNT_W'(MULT_CYCLES); end
`endif
            default: ;
          endcase
        end
        if (load) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (cnt <= CNT_W'(1)) begin
          next_state = ST_IDLE;
          commit     = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: latched result, countdown, architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      busy   <= 1'b0;
      hi_nxt <= '0;
      lo_nxt <= '0;
      wr_q   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      busy <= (next_state == ST_RUN);
      if (load) begin
        cnt    <= cnt_load;
        hi_nxt <= res_hi;
        lo_nxt <= res_lo;
        wr_q   <= wr_c;
      end else if (state == ST_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit && wr_q) begin
        HI <= hi_nxt;
        LO <= lo_nxt;
      end
      if (mt_hi) HI <= A;
      if (mt_lo) LO <= A;
    end
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration in cycles for MULT/MULTU/MADD/MADDU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration in cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  issue strobe from the E stage, sampled at the clk rising edge.
REQ-006 SHALL have port op  input  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
REQ-007 SHALL have port A  input  32  rs operand, already forwarded.
REQ-008 SHALL have port B  input  32  rt operand, already forwarded.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; the hazard unit stalls on (start & ~mt-op) | busy.
REQ-010 SHALL have port HI  output  32  architectural HI, read by MFHI and written to the register file in W.
REQ-011 SHALL have port LO  output  32  architectural LO, read by MFLO.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 IDLE with start=1 and op in {0,1,2,3,6,7}: latch A and B, compute the result into internal hi_nxt/lo_nxt, load cnt = MULT_CYCLES or DIV_CYCLES, go to RUN.
REQ-014 RUN: decrement cnt each cycle; when cnt reaches 1, copy hi_nxt/lo_nxt to HI/LO at that edge and return to IDLE.
REQ-015 busy SHALL equal (state==RUN) as a registered signal, so it is high for exactly N cycles starting the cycle after start.
REQ-016 HI/LO SHALL NOT change while busy=1; the new values SHALL become visible in the same cycle busy falls.
REQ-017 MULT SHALL compute {HI,LO} = signed A * signed B (64-bit); MULTU SHALL compute the unsigned product.
REQ-018 DIV SHALL produce LO = quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL produce the unsigned quotient and remainder.
REQ-019 DIV with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-020 DIV or DIVU with B=0 SHALL still run DIV_CYCLES, and HI/LO SHALL remain unchanged.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write A to HI/LO at that edge, with no busy cycles.
REQ-022 start while busy=1 SHALL be ignored; the in-flight operation SHALL complete unaffected.
REQ-023 Completion and a new start in the same edge are impossible, because busy is still 1 at that edge; the new start SHALL be ignored per REQ-022.
REQ-024 op values 6 and 7 without the macro of REQ-029 SHALL be treated as no-ops: no state change, busy stays 0.

Reset
REQ-025 reset=0 SHALL asynchronously force state=IDLE, cnt=0, busy=0, HI=0, LO=0, and clear hi_nxt/lo_nxt and the latched operands.
REQ-026 reset asserted mid-RUN SHALL abort the operation; HI/LO SHALL read 0 after reset.
REQ-027 Deassertion of reset SHALL take effect at the next rising edge; there is no output change between reset release and the first start.

Configuration
REQ-028 The only compile-time option SHALL be macro MUL_DIV_UNIT_MADD_EN.
REQ-029 When defined: MADD SHALL compute {HI,LO} += signed A*B and MADDU SHALL compute {HI,LO} += unsigned A*B, modulo 2^64; the accumulate base is HI/LO sampled at start; each runs MULT_CYCLES.
REQ-030 When undefined: REQ-024 applies and no accumulate adder is synthesized.

Structure
REQ-031 A shared package mdu_pkg SHALL hold the op encodings (MDU_MULT..MDU_MADDU), the FSM state encoding, and the default cycle constants.
REQ-032 cnt width SHALL be $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
REQ-033 The design SHALL be a single module with no sub-module; arithmetic uses behavioural *, / and %.

Verification
REQ-034 MULT with A=0xFFFFFFFE (-2) and B=3 -> busy=1 for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-035 DIVU with A=100 and B=7 -> busy=1 for 10 cycles, then LO=14 and HI=2; DIV with A=-7 and B=2 -> LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-036 MTLO with A=0x12345678 -> LO=0x12345678 at the next edge, busy never 1; a following DIV with B=0 -> 10 busy cycles, then LO=0x12345678 unchanged.
REQ-037 MULTU with A=B=0xFFFFFFFF, plus a second start on cycle 2 of the operation -> second start ignored; HI=0xFFFFFFFE and LO=0x00000001.
REQ-038 MULT in progress with reset pulsed low on cycle 3 -> busy=0 and HI=LO=0 immediately, with no later update.
REQ-039 With MUL_DIV_UNIT_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then MADDU with A=1 and B=1 -> HI=1 and LO=0 after 5 cycles; without the macro -> HI and LO unchanged and busy=0.
